// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The o_overflow member exists only when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_operand_a;
    logic [WIDTH-1:0] i_operand_b;
    logic             i_borrow;
    logic             o_ready;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_difference;
    logic             o_borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             o_overflow;

    modport master (
        output i_start, i_operand_a, i_operand_b, i_borrow,
        input  o_ready, o_busy, o_done, o_difference, o_borrow, o_overflow
    );

    modport slave (
        input  i_start, i_operand_a, i_operand_b, i_borrow,
        output o_ready, o_busy, o_done, o_difference, o_borrow, o_overflow
    );
`else
    modport master (
        output i_start, i_operand_a, i_operand_b, i_borrow,
        input  o_ready, o_busy, o_done, o_difference, o_borrow
    );

    modport slave (
        input  i_start, i_operand_a, i_operand_b, i_borrow,
        output o_ready, o_busy, o_done, o_difference, o_borrow
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - borrow_in, LSB first, one bit per clock with a single borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    serial_subtractor_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sr_reg, a_sr_next;
    logic [WIDTH-1:0] b_sr_reg, b_sr_next;
    logic [WIDTH-1:0] res_sr_reg, res_sr_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             br_reg, br_next;
    logic             borrow_out_reg, borrow_out_next;

    logic             bit_d;
    logic             bit_br;
    logic [WIDTH-1:0] res_shifted;
    logic [WIDTH-1:0] a_shifted;
    logic [WIDTH-1:0] b_shifted;

    // One full-subtractor slice operating on the current LSBs.
    assign bit_d  = a_sr_reg[0] ^ b_sr_reg[0] ^ br_reg;
    assign bit_br = (~a_sr_reg[0] & b_sr_reg[0]) | (~(a_sr_reg[0] ^ b_sr_reg[0]) & br_reg);

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign res_shifted[gi] = res_sr_reg[gi + 1];
            assign a_shifted[gi]   = a_sr_reg[gi + 1];
            assign b_shifted[gi]   = b_sr_reg[gi + 1];
        end
    endgenerate

    // New difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign res_shifted[WIDTH-1] = bit_d;
    assign a_shifted[WIDTH-1]   = 1'b0;
    assign b_shifted[WIDTH-1]   = 1'b0;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic a_msb_reg, a_msb_next;
    logic b_msb_reg, b_msb_next;
    logic ovf_reg, ovf_next;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        a_sr_next       = a_sr_reg;
        b_sr_next       = b_sr_reg;
        res_sr_next     = res_sr_reg;
        diff_next       = diff_reg;
        cnt_next        = cnt_reg;
        br_next         = br_reg;
        borrow_out_next = borrow_out_reg;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        a_msb_next      = a_msb_reg;
        b_msb_next      = b_msb_reg;
        ovf_next        = ovf_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (bus.i_start) begin
                    a_sr_next   = bus.i_operand_a;
                    b_sr_next   = bus.i_operand_b;
                    br_next     = bus.i_borrow;
                    res_sr_next = '0;
                    cnt_next    = '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    a_msb_next  = bus.i_operand_a[WIDTH-1];
                    b_msb_next  = bus.i_operand_b[WIDTH-1];
`endif
                    state_next  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                res_sr_next = res_shifted;
                a_sr_next   = a_shifted;
                b_sr_next   = b_shifted;
                br_next     = bit_br;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_BIT) begin
                    diff_next       = res_shifted;
                    borrow_out_next = bit_br;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    // bit_d is the result MSB on the final bit-cycle.
                    ovf_next        = (a_msb_reg != b_msb_reg) && (bit_d != a_msb_reg);
`endif
                    state_next      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_sr_reg       <= '0;
            b_sr_reg       <= '0;
            res_sr_reg     <= '0;
            diff_reg       <= '0;
            cnt_reg        <= '0;
            br_reg         <= 1'b0;
            borrow_out_reg <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            a_msb_reg      <= 1'b0;
            b_msb_reg      <= 1'b0;
            ovf_reg        <= 1'b0;
`endif
        end else begin
            a_sr_reg       <= a_sr_next;
            b_sr_reg       <= b_sr_next;
            res_sr_reg     <= res_sr_next;
            diff_reg       <= diff_next;
            cnt_reg        <= cnt_next;
            br_reg         <= br_next;
            borrow_out_reg <= borrow_out_next;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            a_msb_reg      <= a_msb_next;
            b_msb_reg      <= b_msb_next;
            ovf_reg        <= ovf_next;
`endif
        end
    end

    assign bus.o_ready      = (state_reg == ST_IDLE);
    assign bus.o_busy       = (state_reg == ST_BUSY);
    assign bus.o_done       = (state_reg == ST_DONE);
    assign bus.o_difference = diff_reg;
    assign bus.o_borrow     = borrow_out_reg;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    assign bus.o_overflow   = ovf_reg;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level timeline model plus directed
// literal checks and a randomized sweep.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {overflow, borrow, difference} straight from unsigned arithmetic.
    function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] full;
        logic       ovf;
        full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        ovf  = (a[7] != b[7]) && (full[7] != a[7]);
        return {ovf, full};
    endfunction

    // Timeline model: an accepted op keeps the block busy for WIDTH cycles,
    // then shows done for one cycle, then the block is idle again.
    int         remaining   = 0;
    bit         done_now    = 1'b0;
    bit         model_live  = 1'b0;
    int         accepts     = 0;
    logic [7:0] exp_diff    = 8'h00;
    bit         exp_borrow  = 1'b0;
    bit         exp_ovf     = 1'b0;
    logic [9:0] pend        = 10'h000;

    always @(posedge clk) begin
        model_live <= 1'b1;
        if (rst) begin
            remaining  <= 0;
            done_now   <= 1'b0;
            exp_diff   <= 8'h00;
            exp_borrow <= 1'b0;
            exp_ovf    <= 1'b0;
        end else if (remaining == 0 && !done_now) begin
            if (bus.i_start === 1'b1) begin
                remaining <= WIDTH;
                pend      <= ref_sub(bus.i_operand_a, bus.i_operand_b, bus.i_borrow);
                accepts   <= accepts + 1;
            end
        end else if (remaining > 0) begin
            remaining <= remaining - 1;
            if (remaining == 1) begin
                done_now   <= 1'b1;
                exp_diff   <= pend[7:0];
                exp_borrow <= pend[8];
                exp_ovf    <= pend[9];
            end
        end else begin
            done_now <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("o_ready", 32'(bus.o_ready), 32'(remaining == 0 && !done_now));
            chk("o_busy", 32'(bus.o_busy), 32'(remaining > 0));
            chk("o_done", 32'(bus.o_done), 32'(done_now));
            chk("o_difference", 32'(bus.o_difference), 32'(exp_diff));
            chk("o_borrow", 32'(bus.o_borrow), 32'(exp_borrow));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            chk("o_overflow", 32'(bus.o_overflow), 32'(exp_ovf));
`endif
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (bus.o_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 32'(bus.o_ready), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] ed, input logic eb, input int elat);
        int k;
        wait_ready();
        bus.i_operand_a = a;
        bus.i_operand_b = b;
        bus.i_borrow    = bin;
        bus.i_start     = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.o_done !== 1'b1 && k < 40);
        $display("op %02h - %02h - %0d -> diff %02h borrow %0b after %0d edges",
                 a, b, bin, bus.o_difference, bus.o_borrow, k);
        chk("latency", 32'(k), 32'(elat));
        chk("lit_diff", 32'(bus.o_difference), 32'(ed));
        chk("lit_borrow", 32'(bus.o_borrow), 32'(eb));
    endtask

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    task automatic run_ovf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed, input logic eo);
        run_op(a, b, 1'b0, ed, 1'b0, WIDTH);
        chk("lit_overflow", 32'(bus.o_overflow), 32'(eo));
    endtask
`endif

    initial begin
        int k;
        int dones;
        int base;
        rst             = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_operand_a = '0;
        bus.i_operand_b = '0;
        bus.i_borrow    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.o_ready), 32'd1);
        chk("reset_diff", 32'(bus.o_difference), 32'd0);
        rst = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, WIDTH);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, WIDTH);
        run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, WIDTH);
        run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, WIDTH);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        run_ovf(8'h80, 8'h01, 8'h7F, 1'b1);
        run_ovf(8'h7F, 8'h01, 8'h7E, 1'b0);
`endif

        // start held high through BUSY and DONE must not queue a second op
        wait_ready();
        bus.i_operand_a = 8'h05;
        bus.i_operand_b = 8'h03;
        bus.i_borrow    = 1'b0;
        bus.i_start     = 1'b1;
        @(negedge clk);
        bus.i_operand_a = 8'hAA;
        bus.i_operand_b = 8'h01;
        dones = 0;
        for (int i = 0; i < WIDTH + 1; i++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                dones++;
                chk("held_first_diff", 32'(bus.o_difference), 32'h02);
            end
        end
        chk("held_single_done", 32'(dones), 32'd1);
        k = 0;
        while (bus.o_busy !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        bus.i_start = 1'b0;
        k = 0;
        while (bus.o_done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        $display("held-start second op -> diff %02h", bus.o_difference);
        chk("held_second_diff", 32'(bus.o_difference), 32'hA9);

        // reset in the 4th BUSY cycle discards the op
        wait_ready();
        bus.i_operand_a = 8'h33;
        bus.i_operand_b = 8'h11;
        bus.i_start     = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 32'(bus.o_ready), 32'd1);
        chk("midrst_diff", 32'(bus.o_difference), 32'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) dones++;
        end
        $display("mid-BUSY reset -> %0d done pulses afterwards", dones);
        chk("midrst_no_done", 32'(dones), 32'd0);

        // randomized sweep, checked every cycle by the compare process
        base = accepts;
        k = 0;
        while ((accepts - base) < 1000 && k < 30000) begin
            bus.i_operand_a = 8'($urandom);
            bus.i_operand_b = 8'($urandom);
            bus.i_borrow    = 1'($urandom);
            bus.i_start     = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.o_done === 1'b1)
                $display("rand op done: diff %02h borrow %0b", bus.o_difference, bus.o_borrow);
            k++;
        end
        bus.i_start = 1'b0;
        chk("random_ops", 32'((accepts - base) >= 1000), 32'd1);
        repeat (WIDTH + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
